// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter sharing the Sysbus read port between line-fill requesters.
// Issues one line read per grant and assembles the BEATS-beat burst into a cache line.

`ifndef SYSBUS_READ
`define SYSBUS_READ 1'b1
`endif
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

module sysbus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int NREQ           = 2,
  parameter int BEATS          = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NREQ-1:0]                   req,
  input  logic [NREQ*BUS_DATA_WIDTH-1:0]    req_addr,
  output logic [NREQ-1:0]                   gnt,
  output logic [NREQ-1:0]                   resp_valid,
  output logic [BEATS*BUS_DATA_WIDTH-1:0]   resp_data,
  output logic                              busy,
  output logic                              bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]         bus_req,
  output logic [BUS_TAG_WIDTH-1:0]          bus_reqtag,
  input  logic                              bus_reqack,
  input  logic                              bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]         bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]          bus_resptag,
  output logic                              bus_respack
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t                    state_q;
  logic [OW-1:0]             owner_q;
  logic [OW-1:0]             rr_q;
  logic [OW-1:0]             rr_d;
  logic [BW-1:0]             beat_q;
  logic [BUS_DATA_WIDTH-1:0] addr_q;
  logic [BUS_DATA_WIDTH-1:0] line_q [BEATS];
  logic [BUS_DATA_WIDTH-1:0] resp_q [BEATS];

  logic [OW-1:0]             pick;
  logic                      pick_vld;
  int                        scan_idx;
  logic [BUS_DATA_WIDTH-1:0] pick_addr;
  logic [NREQ-1:0]           owner_hot;
  logic                      beat_acc;
  logic                      last_acc;
  logic                      unused_tag_bits;

  // First requester at or above rr_q, wrapping around.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(rr_q) + k) % NREQ;
      if (!pick_vld && req[scan_idx]) begin
        pick     = OW'(scan_idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign pick_addr = req_addr[int'(pick)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
  assign rr_d      = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + 1'b1;

  assign beat_acc = (state_q == S_RESP) && bus_respcyc &&
                    (bus_resptag[7:0] == 8'(owner_q));
  assign last_acc = beat_acc && (beat_q == BW'(BEATS-1));
  assign unused_tag_bits = ^bus_resptag[BUS_TAG_WIDTH-1:8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            owner_q <= pick;
            addr_q  <= {pick_addr[BUS_DATA_WIDTH-1:6], 6'b0};
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_reqack) begin
            beat_q  <= '0;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          if (beat_acc) begin
            beat_q <= beat_q + 1'b1;
            if (last_acc) state_q <= S_DONE;
          end
        end
        default: begin
          rr_q    <= rr_d;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Beats fill the working line; the visible line is only replaced on the last beat.
  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        line_q[gi] <= '0;
        resp_q[gi] <= '0;
      end else begin
        if (beat_acc && beat_q == BW'(gi)) line_q[gi] <= bus_resp;
        if (last_acc) resp_q[gi] <= (beat_q == BW'(gi)) ? bus_resp : line_q[gi];
      end
    end
    assign resp_data[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = resp_q[gi];
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_hot
    assign owner_hot[gi] = (owner_q == OW'(gi));
  end

  assign gnt         = owner_hot & {NREQ{(state_q == S_REQ) && bus_reqack}};
  assign resp_valid  = owner_hot & {NREQ{state_q == S_DONE}};
  assign busy        = (state_q != S_IDLE);
  assign bus_reqcyc  = (state_q == S_REQ);
  assign bus_req     = bus_reqcyc ? addr_q : '0;
  assign bus_reqtag  = bus_reqcyc ?
                       BUS_TAG_WIDTH'({`SYSBUS_READ, `SYSBUS_MEMORY, 8'(owner_q)}) : '0;
  assign bus_respack = beat_acc;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: single reads, contention, gapped/foreign beats,
// stalled ack, reset mid-burst and early request drop.

module tb_sysbus_arbiter;
  localparam int NREQ = 2;
  localparam int W    = 64;
  localparam int TW   = 13;
  localparam int LW   = 512;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_addr;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   resp_valid;
  logic [LW-1:0]     resp_data;
  logic              busy;
  logic              bus_reqcyc;
  logic [W-1:0]      bus_req;
  logic [TW-1:0]     bus_reqtag;
  logic              bus_reqack;
  logic              bus_respcyc;
  logic [W-1:0]      bus_resp;
  logic [TW-1:0]     bus_resptag;
  logic              bus_respack;

  int total = 0;
  int bad   = 0;
  logic [LW-1:0] last_line;

  sysbus_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .gnt(gnt), .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] beat_data(input int own, input int k);
    return {16'hD0D0, 8'(own), 8'(k), 32'h1234_0000 + 32'(k * 7)};
  endfunction

  function automatic logic [TW-1:0] exp_tag(input int own);
    return 13'h1100 | 13'(own);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    LW'(gnt),         LW'(0));
    chk({tag, "_rvld"},   LW'(resp_valid),  LW'(0));
    chk({tag, "_rdata"},  resp_data,        LW'(0));
    chk({tag, "_busy"},   LW'(busy),        LW'(0));
    chk({tag, "_reqcyc"}, LW'(bus_reqcyc),  LW'(0));
    chk({tag, "_busreq"}, LW'(bus_req),     LW'(0));
    chk({tag, "_reqtag"}, LW'(bus_reqtag),  LW'(0));
    chk({tag, "_respack"},LW'(bus_respack), LW'(0));
  endtask

  task automatic wait_reqcyc(input string tag);
    for (int n = 0; n < 12; n++) begin
      #1;
      if (bus_reqcyc) break;
      @(negedge clk);
    end
    chk({tag, "_reqcyc_wait"}, LW'(bus_reqcyc), LW'(1));
  endtask

  // Entered with the DUT in REQ; runs the full request/response/done sequence.
  task automatic txn(input string tag, input int own, input logic [W-1:0] raw,
                     input int ack_wait, input bit gap, input bit drop);
    logic [LW-1:0] model;
    logic [W-1:0]  aligned;
    aligned = {raw[W-1:6], 6'b0};
    for (int k = 0; k < 8; k++) model[64*k +: 64] = beat_data(own, k);
    for (int w = 0; w < ack_wait; w++) begin
      bus_reqack = 1'b0;
      #1;
      chk({tag, "_stall_reqcyc"}, LW'(bus_reqcyc), LW'(1));
      chk({tag, "_stall_addr"},   LW'(bus_req),    LW'(aligned));
      chk({tag, "_stall_tag"},    LW'(bus_reqtag), LW'(exp_tag(own)));
      chk({tag, "_stall_gnt"},    LW'(gnt),        LW'(0));
      @(negedge clk);
    end
    bus_reqack = 1'b1;
    #1;
    chk({tag, "_gnt"},    LW'(gnt),        LW'(1 << own));
    chk({tag, "_addr"},   LW'(bus_req),    LW'(aligned));
    chk({tag, "_tag"},    LW'(bus_reqtag), LW'(exp_tag(own)));
    @(negedge clk);
    bus_reqack = 1'b0;
    if (drop) req[own] = 1'b0;
    #1;
    chk({tag, "_reqcyc_off"}, LW'(bus_reqcyc), LW'(0));
    chk({tag, "_gnt_off"},    LW'(gnt),        LW'(0));
    for (int k = 0; k < 8; k++) begin
      if (gap && k == 3) begin
        for (int g = 0; g < 2; g++) begin
          bus_respcyc = 1'b0;
          #1;
          chk({tag, "_gap_ack"}, LW'(bus_respack), LW'(0));
          @(negedge clk);
        end
        bus_respcyc = 1'b1;
        bus_resp    = 64'hBAD0_BAD0_BAD0_BAD0;
        bus_resptag = exp_tag(own ^ 1);
        #1;
        chk({tag, "_foreign_ack"}, LW'(bus_respack), LW'(0));
        @(negedge clk);
      end
      bus_respcyc = 1'b1;
      bus_resp    = beat_data(own, k);
      bus_resptag = exp_tag(own);
      #1;
      chk({tag, "_beat_ack"},  LW'(bus_respack), LW'(1));
      chk({tag, "_hold_line"}, resp_data,        last_line);
      chk({tag, "_beat_rvld"}, LW'(resp_valid),  LW'(0));
      @(negedge clk);
    end
    bus_respcyc = 1'b0;
    #1;
    chk({tag, "_rvld"},  LW'(resp_valid), LW'(1 << own));
    chk({tag, "_line"},  resp_data,       model);
    last_line = model;
    @(negedge clk);
    #1;
    chk({tag, "_rvld_off"}, LW'(resp_valid), LW'(0));
    chk({tag, "_idle"},     LW'(busy),       LW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req = '0; req_addr = '0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    last_line = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_busy", LW'(busy), LW'(0));

    // Single read, ack in the second REQ cycle
    @(negedge clk);
    req_addr[63:0] = 64'h1000_0004; req = 2'b01;
    @(negedge clk);
    txn("t1", 0, 64'h1000_0004, 1, 1'b0, 1'b1);

    // Gapped beats with a foreign-tag beat in the middle
    @(negedge clk);
    req_addr[63:0] = 64'h2000_0040; req = 2'b01;
    @(negedge clk);
    txn("t3", 0, 64'h2000_0040, 0, 1'b1, 1'b1);

    // Stalled ack for 20 cycles on requester 1
    @(negedge clk);
    req_addr[127:64] = 64'h3000_0ABC; req = 2'b10;
    @(negedge clk);
    txn("t4", 1, 64'h3000_0ABC, 20, 1'b0, 1'b1);

    // Request dropped after a single cycle
    @(negedge clk);
    req_addr[63:0] = 64'h4000_007F; req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    txn("t6", 0, 64'h4000_007F, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("t6_after_gnt",  LW'(gnt),        LW'(0));
      chk("t6_after_rvld", LW'(resp_valid), LW'(0));
      chk("t6_after_busy", LW'(busy),       LW'(0));
    end

    // Reset after beat 3, remaining beats arrive once idle
    @(negedge clk);
    req_addr[63:0] = 64'h5000_0100; req = 2'b01;
    @(negedge clk);
    bus_reqack = 1'b1;
    #1;
    chk("t5_gnt", LW'(gnt), LW'(1));
    @(negedge clk);
    bus_reqack = 1'b0; req = 2'b00;
    for (int k = 0; k < 4; k++) begin
      bus_respcyc = 1'b1; bus_resp = beat_data(0, k); bus_resptag = exp_tag(0);
      #1;
      chk("t5_beat_ack", LW'(bus_respack), LW'(1));
      @(negedge clk);
    end
    reset = 1'b1;
    bus_resp = beat_data(0, 4);
    #1;
    chk_all_zero("t5_rst");
    @(negedge clk);
    #1;
    chk_all_zero("t5_rst2");
    reset = 1'b0;
    last_line = '0;
    for (int k = 4; k < 8; k++) begin
      @(negedge clk);
      bus_respcyc = 1'b1; bus_resp = beat_data(0, k); bus_resptag = exp_tag(0);
      #1;
      chk("t5_late_ack",  LW'(bus_respack), LW'(0));
      chk("t5_late_busy", LW'(busy),        LW'(0));
      chk("t5_late_rvld", LW'(resp_valid),  LW'(0));
    end
    @(negedge clk);
    bus_respcyc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("t5_post_rvld", LW'(resp_valid), LW'(0));
      chk("t5_post_busy", LW'(busy),       LW'(0));
      chk("t5_post_line", resp_data,       LW'(0));
    end

    // Contention from reset: grants must alternate 0,1,0,1
    @(negedge clk);
    reset = 1'b1;
    req_addr = {64'h7000_0040, 64'h6000_0000};
    req = 2'b11;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_line = '0;
    for (int i = 0; i < 4; i++) begin
      wait_reqcyc("t2");
      if (i % 2 == 0) txn("t2_own0", 0, 64'h6000_0000, 0, 1'b0, 1'b0);
      else            txn("t2_own1", 1, 64'h7000_0040, 0, 1'b0, 1'b0);
    end
    req = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
